// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - ID-stage hazard controller: load-use countdown, long-op scoreboard, branch flush, perf counters
module hazard_ctrl #(
  parameter int REG_W      = 5,
  parameter int LOAD_STALL = 1,
  parameter int CNT_W      = 4,
  parameter int NUM_PEND   = 4,
  parameter int PERF_W     = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_W-1:0]  id_rs1,
  input  logic [REG_W-1:0]  id_rs2,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic              id_is_lop,
  input  logic              ex_mem_read,
  input  logic [REG_W-1:0]  ex_rd,
  input  logic              lop_issue,
  input  logic [REG_W-1:0]  lop_rd,
  input  logic              lop_done,
  input  logic [REG_W-1:0]  lop_done_rd,
  input  logic              jb_attempt_branch,
  input  logic              jb_branch_taken,
  input  logic              jb_predict_taken,
  input  logic              jb_jump,
  output logic              stall,
  output logic              flush,
  output logic              mispredict,
  output logic              sb_full,
  output logic [PERF_W-1:0] perf_mispredicts,
  output logic [PERF_W-1:0] perf_stall_cycles
);

  localparam bit LU_EN = (LOAD_STALL != 0);
  localparam bit MULTI = (LOAD_STALL > 1);
  localparam logic [CNT_W-1:0] CNT_INIT = MULTI ? CNT_W'(LOAD_STALL - 2) : '0;

  typedef enum logic {IDLE, COUNT} state_t;

  state_t            state, state_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic [NUM_PEND-1:0] sb_valid, alloc_oh, free_oh;
  logic [REG_W-1:0]  sb_rd [NUM_PEND];
  logic [PERF_W-1:0] mis_cnt, stall_cnt;
  logic lu_hit, lu, sb_hit, sb_stall, lu_fsm_stall, do_alloc;
  logic alloc_found, free_found;

  always_comb begin
    lu_hit = (ex_rd != '0) &&
             ((id_rs1_used && id_rs1 == ex_rd) || (id_rs2_used && id_rs2 == ex_rd));
  end

  // A long op completing this cycle is bypassed from WB, so its entry does not stall ID.
  always_comb begin
    sb_hit      = 1'b0;
    alloc_oh    = '0;
    free_oh     = '0;
    alloc_found = 1'b0;
    free_found  = 1'b0;
    for (int i = 0; i < NUM_PEND; i++) begin
      if (sb_valid[i] && sb_rd[i] != '0 &&
          ((id_rs1_used && id_rs1 == sb_rd[i]) || (id_rs2_used && id_rs2 == sb_rd[i])) &&
          !(lop_done && sb_rd[i] == lop_done_rd))
        sb_hit = 1'b1;
      if (!sb_valid[i] && !alloc_found) begin
        alloc_oh[i] = 1'b1;
        alloc_found = 1'b1;
      end
      if (sb_valid[i] && sb_rd[i] == lop_done_rd && !free_found) begin
        free_oh[i] = 1'b1;
        free_found = 1'b1;
      end
    end
  end

  assign sb_full    = &sb_valid;
  assign mispredict = rst_n & jb_attempt_branch & (jb_branch_taken ^ jb_predict_taken);
  assign flush      = rst_n & (mispredict | jb_jump);
  assign lu         = LU_EN & ex_mem_read & lu_hit;
  assign sb_stall   = sb_hit | (id_is_lop & sb_full);
  assign stall      = rst_n & ~flush & (lu_fsm_stall | sb_stall);
  assign do_alloc   = lop_issue & ~stall & ~flush & (lop_rd != '0) & ~sb_full;

  assign perf_mispredicts  = mis_cnt;
  assign perf_stall_cycles = stall_cnt;

  // First stall cycle comes from IDLE; COUNT supplies the remaining LOAD_STALL-1.
  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    lu_fsm_stall = 1'b0;
    case (state)
      IDLE: begin
        if (lu) begin
          lu_fsm_stall = 1'b1;
          if (!flush && MULTI) begin
            state_nx = COUNT;
            cnt_nx   = CNT_INIT;
          end
        end
      end
      COUNT: begin
        lu_fsm_stall = 1'b1;
        if (flush) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else if (cnt == '0) begin
          state_nx = IDLE;
        end else begin
          cnt_nx = cnt - CNT_W'(1);
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_valid <= '0;
      for (int i = 0; i < NUM_PEND; i++) sb_rd[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_PEND; i++) begin
        if (lop_done && free_oh[i]) sb_valid[i] <= 1'b0;
        if (do_alloc && alloc_oh[i]) begin
          sb_valid[i] <= 1'b1;
          sb_rd[i]    <= lop_rd;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mis_cnt   <= '0;
      stall_cnt <= '0;
    end else begin
      if (mispredict && mis_cnt != '1) mis_cnt <= mis_cnt + PERF_W'(1);
      if (stall && stall_cnt != '1) stall_cnt <= stall_cnt + PERF_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - bench for hazard_ctrl: two parameterisations against a behavioural model
module tb_hazard_ctrl;
  localparam int NP = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [4:0] id_rs1, id_rs2, ex_rd, lop_rd, lop_done_rd;
  logic id_rs1_used, id_rs2_used, id_is_lop, ex_mem_read, lop_issue, lop_done;
  logic jb_attempt_branch, jb_branch_taken, jb_predict_taken, jb_jump;

  logic stall_a, flush_a, mis_a, full_a;
  logic [31:0] pm_a, ps_a;
  logic stall_b, flush_b, mis_b, full_b;
  logic [3:0] pm_b, ps_b;

  hazard_ctrl #(.REG_W(5), .LOAD_STALL(1), .CNT_W(4), .NUM_PEND(NP), .PERF_W(32)) dut_a (
    .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_is_lop(id_is_lop),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .lop_issue(lop_issue), .lop_rd(lop_rd),
    .lop_done(lop_done), .lop_done_rd(lop_done_rd), .jb_attempt_branch(jb_attempt_branch),
    .jb_branch_taken(jb_branch_taken), .jb_predict_taken(jb_predict_taken), .jb_jump(jb_jump),
    .stall(stall_a), .flush(flush_a), .mispredict(mis_a), .sb_full(full_a),
    .perf_mispredicts(pm_a), .perf_stall_cycles(ps_a));

  hazard_ctrl #(.REG_W(5), .LOAD_STALL(3), .CNT_W(4), .NUM_PEND(NP), .PERF_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_is_lop(id_is_lop),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .lop_issue(lop_issue), .lop_rd(lop_rd),
    .lop_done(lop_done), .lop_done_rd(lop_done_rd), .jb_attempt_branch(jb_attempt_branch),
    .jb_branch_taken(jb_branch_taken), .jb_predict_taken(jb_predict_taken), .jb_jump(jb_jump),
    .stall(stall_b), .flush(flush_b), .mispredict(mis_b), .sb_full(full_b),
    .perf_mispredicts(pm_b), .perf_stall_cycles(ps_b));

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    string       name;
    int          sig;
    logic [63:0] exp;
  } lit_t;
  lit_t lq[$];

  // Model state per instance: pending long ops, remaining load-use stall cycles, counters.
  int          ls_of[2] = '{1, 3};
  longint      pmax[2]  = '{64'hFFFF_FFFF, 15};
  bit          mv[2][NP];
  logic [4:0]  mrd[2][NP];
  int          lrem[2];
  longint      mpm[2], mps[2];

  function automatic logic [63:0] sig_val(input int id);
    case (id)
      0:  return {63'd0, stall_a};
      1:  return {63'd0, flush_a};
      2:  return {63'd0, mis_a};
      3:  return {63'd0, full_a};
      4:  return {32'd0, pm_a};
      5:  return {32'd0, ps_a};
      6:  return {63'd0, stall_b};
      7:  return {63'd0, flush_b};
      8:  return {63'd0, mis_b};
      9:  return {63'd0, full_b};
      10: return {60'd0, pm_b};
      default: return {60'd0, ps_b};
    endcase
  endfunction

  function automatic bit hit(input logic [4:0] r);
    return (r != 0) && ((id_rs1_used && id_rs1 == r) || (id_rs2_used && id_rs2 == r));
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_cycle(input int k);
    bit e_mis, e_fl, e_st, e_full, lu, sbh;
    int n, ai, fi, b;
    b = k * 6;
    if (!rst_n) begin
      for (int j = 0; j < NP; j++) begin
        mv[k][j]  = 1'b0;
        mrd[k][j] = '0;
      end
      lrem[k] = 0;
      mpm[k]  = 0;
      mps[k]  = 0;
      check($sformatf("rst_stall[%0d]", k), sig_val(b + 0), 0);
      check($sformatf("rst_flush[%0d]", k), sig_val(b + 1), 0);
      check($sformatf("rst_mis[%0d]", k),   sig_val(b + 2), 0);
      check($sformatf("rst_full[%0d]", k),  sig_val(b + 3), 0);
      check($sformatf("rst_pm[%0d]", k),    sig_val(b + 4), 0);
      check($sformatf("rst_ps[%0d]", k),    sig_val(b + 5), 0);
      return;
    end
    e_mis = jb_attempt_branch && (jb_branch_taken != jb_predict_taken);
    e_fl  = e_mis || jb_jump;
    lu    = ex_mem_read && hit(ex_rd) && (ls_of[k] != 0);
    n = 0;
    sbh = 1'b0;
    for (int j = 0; j < NP; j++) begin
      if (mv[k][j]) begin
        n++;
        if (hit(mrd[k][j]) && !(lop_done && mrd[k][j] == lop_done_rd)) sbh = 1'b1;
      end
    end
    e_full = (n == NP);
    e_st   = !e_fl && ((lrem[k] > 0) || lu || sbh || (id_is_lop && e_full));

    check($sformatf("stall[%0d]", k), sig_val(b + 0), {63'd0, e_st});
    check($sformatf("flush[%0d]", k), sig_val(b + 1), {63'd0, e_fl});
    check($sformatf("mis[%0d]", k),   sig_val(b + 2), {63'd0, e_mis});
    check($sformatf("full[%0d]", k),  sig_val(b + 3), {63'd0, e_full});
    check($sformatf("pm[%0d]", k),    sig_val(b + 4), mpm[k]);
    check($sformatf("ps[%0d]", k),    sig_val(b + 5), mps[k]);

    if (e_fl) lrem[k] = 0;
    else if (lrem[k] > 0) lrem[k] = lrem[k] - 1;
    else if (lu) lrem[k] = ls_of[k] - 1;

    ai = -1;
    fi = -1;
    if (lop_issue && !e_st && !e_fl && lop_rd != 0 && !e_full)
      for (int j = NP - 1; j >= 0; j--) if (!mv[k][j]) ai = j;
    if (lop_done)
      for (int j = NP - 1; j >= 0; j--) if (mv[k][j] && mrd[k][j] == lop_done_rd) fi = j;
    if (fi >= 0) mv[k][fi] = 1'b0;
    if (ai >= 0) begin
      mv[k][ai]  = 1'b1;
      mrd[k][ai] = lop_rd;
    end

    if (e_mis && mpm[k] < pmax[k]) mpm[k]++;
    if (e_st && mps[k] < pmax[k]) mps[k]++;
  endtask

  always @(negedge clk) begin
    lit_t l;
    while (lq.size() > 0) begin
      l = lq.pop_front();
      check(l.name, sig_val(l.sig), l.exp);
    end
    for (int k = 0; k < 2; k++) model_cycle(k);
  end

  task automatic want(input string name, input int sig, input longint exp);
    lit_t l;
    l.name = name;
    l.sig  = sig;
    l.exp  = exp;
    lq.push_back(l);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    id_rs1 = 0; id_rs2 = 0; id_rs1_used = 0; id_rs2_used = 0; id_is_lop = 0;
    ex_mem_read = 0; ex_rd = 0; lop_issue = 0; lop_rd = 0; lop_done = 0; lop_done_rd = 0;
    jb_attempt_branch = 0; jb_branch_taken = 0; jb_predict_taken = 0; jb_jump = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    want("lit_rst_full_a", 3, 0);
    want("lit_rst_ps_b", 11, 0);
    cyc();
    cyc();
    rst_n = 1'b1;

    // load-use: one cycle on the LOAD_STALL=1 instance, three on LOAD_STALL=3
    ex_mem_read = 1; ex_rd = 5; id_rs2 = 5; id_rs2_used = 1;
    want("lit_lu_a_t0", 0, 1); want("lit_lu_b_t0", 6, 1);
    cyc(); ex_mem_read = 0;
    want("lit_lu_a_t1", 0, 0); want("lit_lu_b_t1", 6, 1);
    cyc(); want("lit_lu_b_t2", 6, 1);
    cyc(); want("lit_lu_b_t3", 6, 0);
    cyc(); ex_mem_read = 1; ex_rd = 0; id_rs1 = 0; id_rs1_used = 1;
    want("lit_lu_x0_a", 0, 0); want("lit_lu_x0_b", 6, 0);
    cyc(); idle_inputs();

    // jump aborts the countdown
    cyc(); ex_mem_read = 1; ex_rd = 5; id_rs2 = 5; id_rs2_used = 1;
    want("lit_abort_t0", 6, 1);
    cyc(); ex_mem_read = 0; jb_jump = 1;
    want("lit_abort_flush", 7, 1); want("lit_abort_stall_t1", 6, 0);
    cyc(); jb_jump = 0;
    want("lit_abort_stall_t2", 6, 0);
    cyc(); idle_inputs();

    // long op rd=7: stall while pending, released on the writeback cycle
    lop_issue = 1; lop_rd = 7;
    want("lit_sb_issue", 0, 0);
    cyc(); lop_issue = 0; id_rs1 = 7; id_rs1_used = 1;
    want("lit_sb_c1", 0, 1);
    cyc(); want("lit_sb_c2", 0, 1);
    cyc(); want("lit_sb_c3", 0, 1);
    cyc(); lop_done = 1; lop_done_rd = 7;
    want("lit_sb_c4", 0, 0);
    cyc(); lop_done = 0;
    want("lit_sb_freed", 0, 0);
    cyc(); idle_inputs();

    // fill the scoreboard, then free/issue collision
    for (int r = 1; r <= 4; r++) begin
      lop_issue = 1; lop_rd = 5'(r);
      cyc();
    end
    lop_issue = 0; id_is_lop = 1;
    want("lit_full", 3, 1); want("lit_full_lop_stall", 0, 1);
    cyc(); id_is_lop = 0; lop_done = 1; lop_done_rd = 2; lop_issue = 1; lop_rd = 9;
    want("lit_full_hold", 3, 1); want("lit_full_nostall", 0, 0);
    cyc(); lop_done = 0; lop_rd = 10;
    want("lit_full_freed", 3, 0);
    cyc(); lop_issue = 0; id_rs1 = 9; id_rs1_used = 1;
    want("lit_full_again", 3, 1); want("lit_ignored_rd9", 0, 0);
    cyc(); id_rs1 = 10;
    want("lit_reused_rd10", 0, 1);
    cyc(); idle_inputs();
    do_reset();

    // branch resolution
    jb_attempt_branch = 1; jb_branch_taken = 1; jb_predict_taken = 0;
    want("lit_br_flush", 1, 1); want("lit_br_mis", 2, 1);
    cyc(); jb_predict_taken = 1;
    want("lit_br_pm", 4, 1); want("lit_br_ok_flush", 1, 0); want("lit_br_ok_mis", 2, 0);
    cyc(); jb_attempt_branch = 0; jb_jump = 1;
    want("lit_jmp_flush", 1, 1); want("lit_jmp_mis", 2, 0);
    cyc(); idle_inputs();
    do_reset();

    // 20 stall cycles: 4-bit counter saturates at 15
    lop_issue = 1; lop_rd = 3;
    cyc(); lop_issue = 0; id_rs1 = 3; id_rs1_used = 1;
    repeat (20) cyc();
    id_rs1_used = 0; lop_done = 1; lop_done_rd = 3;
    want("lit_sat_ps_b", 11, 15); want("lit_sat_ps_a", 5, 20);
    cyc(); idle_inputs();

    // async reset in the middle of a countdown
    ex_mem_read = 1; ex_rd = 6; id_rs1 = 6; id_rs1_used = 1;
    cyc(); ex_mem_read = 0;
    #2 rst_n = 1'b0;
    want("lit_midrst_stall_b", 6, 0); want("lit_midrst_ps_a", 5, 0);
    cyc(); cyc(); rst_n = 1'b1; idle_inputs();

    for (int i = 0; i < 3000; i++) begin
      cyc();
      id_rs1            = 5'($urandom_range(0, 7));
      id_rs2            = 5'($urandom_range(0, 7));
      id_rs1_used       = 1'($urandom_range(0, 1));
      id_rs2_used       = 1'($urandom_range(0, 1));
      id_is_lop         = ($urandom_range(0, 3) == 0);
      ex_mem_read       = ($urandom_range(0, 3) == 0);
      ex_rd             = 5'($urandom_range(0, 7));
      lop_issue         = ($urandom_range(0, 2) == 0);
      lop_rd            = 5'($urandom_range(0, 7));
      lop_done          = ($urandom_range(0, 2) == 0);
      lop_done_rd       = 5'($urandom_range(0, 7));
      jb_attempt_branch = ($urandom_range(0, 4) == 0);
      jb_branch_taken   = 1'($urandom_range(0, 1));
      jb_predict_taken  = 1'($urandom_range(0, 1));
      jb_jump           = ($urandom_range(0, 9) == 0);
      if (i == 1500) rst_n = 1'b0;
      if (i == 1502) rst_n = 1'b1;
    end
    cyc(); idle_inputs();
    cyc(); cyc();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
